freq_meter: RTL and testbench

//  Measures the frequency of a slow, asynchronous square wave (for example the output of the

---
 rtl/freq_meter_pkg.sv | 23 ++
 rtl/fm_sync_edge.sv | 43 ++++
 rtl/freq_meter.sv | 133 +++++++++++++
 tb/tb_freq_meter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// ============================================================================
//  Module   : freq_meter_pkg
//  Brief    : Shared types and helpers for the freq_meter block.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_meter_pkg;

  // Measurement FSM: waiting for a request, or counting inside a gate window
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } fm_state_t;

  // Width of the gate-window counter; never below one bit
  function automatic int GATE_W(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fm_sync_edge.sv
// ============================================================================
//  Module   : fm_sync_edge
//  Brief    : Multi-stage synchroniser for an asynchronous input followed by a
//             rising-edge detector on the synchronised level.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  // Shift the async input down the chain; remember last synchronised level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-history registers, updated every cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // A level that was already high in the previous cycle is not an edge
  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

`default_nettype wire

// File: rtl/freq_meter.sv
// ============================================================================
//  Module   : freq_meter
//  Brief    : Counts rising edges of a slow asynchronous signal over a fixed
//             gate window of GATE_CYCLES clocks; single-shot or continuous.
//             Optional macro FREQ_METER_OVF_EN adds the ovf saturation flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = 50000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             cont,
  output logic             busy,
  output logic [CNT_W-1:0] freq_count,
  output logic             valid
`ifdef FREQ_METER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int              GW        = GATE_W(GATE_CYCLES);
  localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [GW-1:0]   GATE_ONE  = GW'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic rise;

  fm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .d_async (sig_in),
    .rise    (rise)
  );

  fm_state_t        state_q, state_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [CNT_W-1:0] freq_count_q, freq_count_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] edge_next;
`ifdef FREQ_METER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Next-state logic: window sequencing, saturating edge count, result capture
  always_comb begin
    state_d      = state_q;
    gate_cnt_d   = gate_cnt_q;
    edge_cnt_d   = edge_cnt_q;
    freq_count_d = freq_count_q;
    valid_d      = 1'b0;
`ifdef FREQ_METER_OVF_EN
    ovf_d        = ovf_q;
`endif
    // Count including this cycle's edge, held at all-ones instead of wrapping
    edge_next = (edge_cnt_q == CNT_MAX) ? CNT_MAX : edge_cnt_q + CNT_W'(rise);

    case (state_q)
      ST_IDLE: begin
        if (start || cont) begin
          state_d    = ST_GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
        end
      end
      ST_GATE: begin
        if (gate_cnt_q == GATE_LAST) begin
          // Last cycle of the window: include its edge so the window is exact
          freq_count_d = edge_next;
          valid_d      = 1'b1;
`ifdef FREQ_METER_OVF_EN
          // The count only stops at all-ones, so reaching it means saturation
          ovf_d        = (edge_next == CNT_MAX);
`endif
          gate_cnt_d   = '0;
          edge_cnt_d   = '0;
          if (!cont) begin
            state_d = ST_IDLE;
          end
        end else begin
          gate_cnt_d = gate_cnt_q + GATE_ONE;
          edge_cnt_d = edge_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and output registers; reset aborts any open window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      freq_count_q <= '0;
      valid_q      <= 1'b0;
`ifdef FREQ_METER_OVF_EN
      ovf_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      freq_count_q <= freq_count_d;
      valid_q      <= valid_d;
`ifdef FREQ_METER_OVF_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign busy       = (state_q == ST_GATE);
  assign freq_count = freq_count_q;
  assign valid      = valid_q;
`ifdef FREQ_METER_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_freq_meter.sv
// ============================================================================
//  Module   : tb_freq_meter
//  Brief    : Self-checking bench for freq_meter. Stimulus square waves with
//             random phase/period; expected counts come from the recorded
//             sig_in history sampled at each clock edge.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_meter;

  localparam int GATE = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        cont = 1'b0;
  logic        start2 = 1'b0;
  logic        busy, valid, busy2, valid2;
  logic [31:0] freq_count;
  logic [3:0]  freq_count2;
`ifdef FREQ_METER_OVF_EN
  logic        ovf, ovf2;
`endif

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy), .freq_count(freq_count), .valid(valid)
`ifdef FREQ_METER_OVF_EN
    , .ovf(ovf)
`endif
  );

  freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start2), .cont(1'b0),
    .busy(busy2), .freq_count(freq_count2), .valid(valid2)
`ifdef FREQ_METER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit hist [0:19999];

  // Square-wave generator (sig_per==0 means hold sig_lvl)
  int   sig_per = 0;
  int   ph = 0;
  logic sig_lvl = 1'b0;
  always @(negedge clk) begin
    if (sig_per > 0) begin
      ph = (ph + 1) % sig_per;
      sig_in = (ph < sig_per / 2);
    end else begin
      sig_in = sig_lvl;
    end
  end

  // Record the level seen at each clock edge (reset holds synchroniser at 0)
  always @(posedge clk) begin
    if (cyc < 20000) hist[cyc] = rst ? 1'b0 : sig_in;
    cyc = cyc + 1;
  end

  // Collect every valid pulse
  int          vc0[$], vc1[$];
  logic [31:0] vn0[$], vn1[$];
  logic        vo1[$];
  always @(negedge clk) begin
    if (valid === 1'b1) begin vc0.push_back(cyc); vn0.push_back(freq_count); end
    if (valid2 === 1'b1) begin
      vc1.push_back(cyc); vn1.push_back({28'd0, freq_count2});
`ifdef FREQ_METER_OVF_EN
      vo1.push_back(ovf2);
`else
      vo1.push_back(1'b0);
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Rising edges seen by a window whose request was sampled at edge e0
  function automatic int model_cnt(input int e0);
    int n = 0;
    for (int t = e0 + 1; t <= e0 + GATE; t++)
      if (t >= 3 && hist[t-2] && !hist[t-3]) n++;
    return n;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? vc0.size() : vc1.size();
  endfunction

  // Wait for one window's valid pulse and check timing, count, busy, ovf
  task automatic check_window(input int d, input int e0, input int want_const,
                              input logic want_busy, input int want_ovf, input string tag);
    int k = 0;
    int gc, exp_n;
    logic [31:0] gn;
    logic go;
    while (qsize(d) == 0 && k < 130) begin tick(); k++; end
    total++;
    assert (qsize(d) != 0) else begin
      bad++;
      $error("FAIL %s_timeout: got=0 valid pulses want=1", tag);
    end
    if (qsize(d) == 0) return;
    if (d == 0) begin gc = vc0.pop_front(); gn = vn0.pop_front(); go = 1'b0; end
    else begin gc = vc1.pop_front(); gn = vn1.pop_front(); go = vo1.pop_front(); end
    exp_n = model_cnt(e0);
    if (d == 1 && exp_n > 15) exp_n = 15;
    chk({tag, "_time"}, gc, e0 + GATE + 1);
    chk({tag, "_model"}, gn, exp_n);
    if (want_const >= 0) chk({tag, "_count"}, gn, want_const);
    chk({tag, "_busy"}, (d == 0) ? busy : busy2, want_busy);
`ifdef FREQ_METER_OVF_EN
    if (want_ovf >= 0) chk({tag, "_ovf"}, go, want_ovf[0]);
`else
    if (want_ovf >= 0 && go !== 1'b0) chk({tag, "_ovf"}, go, 0);
`endif
    tick();
    chk({tag, "_vwidth"}, (d == 0) ? valid : valid2, 0);
  endtask

  initial begin : main
    int e0, per;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_count", freq_count, 0);
    chk("rst_valid", valid, 0);
`ifdef FREQ_METER_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;

    // Period 10, single shot, with an ignored start mid-window
    sig_per = 10; ph = $urandom_range(0, 9);
    repeat (20) tick();
    start = 1'b1; e0 = cyc; tick(); start = 1'b0;
    chk("t1_busy_on", busy, 1);
    repeat (30) tick();
    start = 1'b1; tick(); start = 1'b0;
    check_window(0, e0, 10, 1'b0, -1, "t1");
    repeat (10) tick();
    chk("t4_single_valid", vc0.size(), 0);
    chk("t1_idle", busy, 0);

    // Static high level is not an edge
    sig_per = 0; sig_lvl = 1'b1;
    repeat (10) tick();
    start = 1'b1; e0 = cyc; tick(); start = 1'b0;
    check_window(0, e0, 0, 1'b0, -1, "t2");
    sig_lvl = 1'b0;

    // Continuous mode: period 20, switch to 5 mid-run, then drop cont
    sig_per = 20; ph = $urandom_range(0, 19);
    repeat (25) tick();
    cont = 1'b1; start = 1'b1; e0 = cyc; tick(); start = 1'b0;
    chk("t3_busy_on", busy, 1);
    check_window(0, e0, 5, 1'b1, -1, "t3w0");
    check_window(0, e0 + GATE, 5, 1'b1, -1, "t3w1");
    while (cyc < e0 + 250) tick();
    sig_per = 5; ph = ph % 5;
    check_window(0, e0 + 2 * GATE, -1, 1'b1, -1, "t3w2");
    check_window(0, e0 + 3 * GATE, 20, 1'b1, -1, "t3w3");
    while (cyc < e0 + 450) tick();
    cont = 1'b0;
    check_window(0, e0 + 4 * GATE, 20, 1'b0, -1, "t3w4");

    // Reset mid-window aborts with no valid
    sig_per = 8; ph = $urandom_range(0, 7);
    repeat (10) tick();
    start = 1'b1; e0 = cyc; tick(); start = 1'b0;
    while (cyc < e0 + 51) tick();
    rst = 1'b1; #1;
    chk("t5_busy", busy, 0);
    chk("t5_count", freq_count, 0);
    tick();
    chk("t5_valid", valid, 0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (150) tick();
    chk("t5_no_valid", vc0.size(), 0);
    start = 1'b1; e0 = cyc; tick(); start = 1'b0;
    check_window(0, e0, -1, 1'b0, -1, "t5_restart");

    // Random periods (including static levels), checked against the model
    for (int r = 0; r < 5; r++) begin
      per = $urandom_range(0, 30);
      if (per == 1) per = 2;
      sig_per = per; sig_lvl = 1'($urandom_range(0, 1));
      if (per > 0) ph = $urandom_range(0, per - 1);
      repeat ($urandom_range(5, 15)) tick();
      start = 1'b1; e0 = cyc; tick(); start = 1'b0;
      check_window(0, e0, -1, 1'b0, -1, $sformatf("rnd%0d", r));
    end

    // 4-bit counter: saturation then recovery
    sig_per = 4; ph = $urandom_range(0, 3);
    repeat (10) tick();
    start2 = 1'b1; e0 = cyc; tick(); start2 = 1'b0;
    chk("t6_busy_on", busy2, 1);
    check_window(1, e0, 15, 1'b0, 1, "t6sat");
    sig_per = 10; ph = $urandom_range(0, 9);
    repeat (10) tick();
    start2 = 1'b1; e0 = cyc; tick(); start2 = 1'b0;
    check_window(1, e0, 10, 1'b0, 0, "t6rec");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
